// File: rtl/reduction_pkg.sv
// Shared definitions for the reduction accumulator and its tile sequencer:
// mode encodings, sequencer states and the tile/vector array types.
package reduction_pkg;

    localparam int PKG_TILE_SIZE = 4;
    localparam int PKG_ACC_WIDTH = 32;
    localparam int PKG_LEN_W     = 8;

    localparam logic [2:0] MODE_MAC   = 3'b000;
    localparam logic [2:0] MODE_OUTER = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } seq_state_e;

    typedef logic signed [PKG_ACC_WIDTH-1:0] acc_elem_t;
    typedef acc_elem_t [PKG_TILE_SIZE-1:0]   acc_vec_t;
    typedef acc_vec_t  [PKG_TILE_SIZE-1:0]   acc_tile_t;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode == MODE_MAC) || (mode == MODE_OUTER);
    endfunction

endpackage

// File: rtl/reduction_tile_sequencer.sv
// Command-driven issuer between the tile buffer and the reduction accumulator;
// streams tiles, tracks the 2-cycle accumulator pipeline and presents results.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a command; illegal commands pulse cmd_err
// S_CLEAR  | one-cycle accumulator clear ahead of a MAC run
// S_STREAM | passing tiles straight through to the accumulator
// S_DRAIN  | waiting for the final issued tile to leave the pipeline
// S_RESULT | holding res_vec until the downstream handshake
module reduction_tile_sequencer
    import reduction_pkg::*;
#(
    parameter int TILE_SIZE = PKG_TILE_SIZE,
    parameter int ACC_WIDTH = PKG_ACC_WIDTH,
    parameter int LEN_W     = PKG_LEN_W
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             cmd_valid,
    output logic                                             cmd_ready,
    input  logic [2:0]                                       cmd_mode,
    input  logic [LEN_W-1:0]                                 cmd_len,
    output logic                                             cmd_err,
    input  logic                                             tile_valid,
    output logic                                             tile_ready,
    input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] tile_data,
    output logic                                             acc_valid_in,
    output logic                                             acc_clear,
    output logic [2:0]                                       acc_mode,
    output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] acc_mat,
    input  logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0]       acc_vec_out,
    input  logic                                             acc_valid_out,
    output logic                                             res_valid,
    input  logic                                             res_ready,
    output logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0]       res_vec,
    output logic                                             busy
);

    seq_state_e state_q, state_d;
    logic [2:0]       mode_q;
    logic [LEN_W-1:0] rem_q;
    logic [1:0]       last_pipe;
    logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] res_vec_q;

    logic cmd_hs;
    logic cmd_bad;
    logic tile_hs;
    logic final_tile;
    logic capture;

    assign cmd_hs     = (state_q == S_IDLE) && cmd_valid;
    assign cmd_bad    = !mode_legal(cmd_mode) || (cmd_len == '0);
    assign tile_hs    = (state_q == S_STREAM) && tile_valid;
    // MAC produces one result after the last tile; OUTER one result per tile.
    assign final_tile = tile_hs && ((mode_q != MODE_MAC) || (rem_q == LEN_W'(1)));
    assign capture    = (state_q == S_DRAIN) && last_pipe[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_MAC;
            rem_q     <= '0;
            last_pipe <= '0;
            res_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            last_pipe <= {last_pipe[0], final_tile};
            if (cmd_hs) begin
                mode_q <= cmd_mode;
                rem_q  <= cmd_len;
            end
            if (tile_hs && (rem_q != '0)) begin
                rem_q <= rem_q - LEN_W'(1);
            end
            if (capture) begin
                res_vec_q <= acc_vec_out;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        cmd_err      = 1'b0;
        tile_ready   = 1'b0;
        acc_valid_in = 1'b0;
        acc_clear    = 1'b0;
        acc_mat      = '0;
        res_valid    = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        cmd_err = 1'b1;
                    end else if (cmd_mode == MODE_MAC) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_CLEAR: begin
                acc_clear = 1'b1;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                tile_ready   = 1'b1;
                acc_valid_in = tile_valid;
                acc_mat      = tile_data;
                if (final_tile) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pipe[1]) begin
                    // Result is taken regardless; a missing valid flags a pipeline mismatch.
                    cmd_err = !acc_valid_out;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ((mode_q == MODE_OUTER) && (rem_q != '0)) ? S_STREAM : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset aborts immediately, so nothing is offered while it is asserted.
        if (!rst_n) begin
            cmd_ready    = 1'b0;
            cmd_err      = 1'b0;
            tile_ready   = 1'b0;
            acc_valid_in = 1'b0;
            acc_clear    = 1'b0;
            acc_mat      = '0;
            res_valid    = 1'b0;
            busy         = 1'b0;
        end
    end

    assign acc_mode = mode_q;
    assign res_vec  = res_vec_q;

endmodule

// File: tb/tb_reduction_tile_sequencer.sv
// Bench for reduction_tile_sequencer with a behavioural accumulator beside it;
// expected results are column sums computed directly from the issued tiles.
module tb_reduction_tile_sequencer;
    import reduction_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_mode = 3'b000;
    logic [7:0]  cmd_len = 8'd0;
    logic        cmd_err;
    logic        tile_valid = 1'b0;
    logic        tile_ready;
    acc_tile_t   tile_data = '0;
    logic        acc_valid_in;
    logic        acc_clear;
    logic [2:0]  acc_mode;
    acc_tile_t   acc_mat;
    acc_vec_t    acc_vec_out;
    logic        acc_valid_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    acc_vec_t    res_vec;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    int clr_cnt = 0, vin_cnt = 0, err_cnt = 0, busy_cnt = 0, overlap_cnt = 0;

    acc_tile_t tiles [8];

    always #5 clk = ~clk;

    reduction_tile_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_len(cmd_len), .cmd_err(cmd_err),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
        .acc_valid_in(acc_valid_in), .acc_clear(acc_clear), .acc_mode(acc_mode),
        .acc_mat(acc_mat), .acc_vec_out(acc_vec_out), .acc_valid_out(acc_valid_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec), .busy(busy)
    );

    function automatic acc_vec_t colsum(input acc_tile_t t);
        acc_vec_t v;
        longint   s;
        for (int c = 0; c < PKG_TILE_SIZE; c++) begin
            s = 0;
            for (int r = 0; r < PKG_TILE_SIZE; r++) s += longint'(t[r][c]);
            v[c] = acc_elem_t'(s);
        end
        return v;
    endfunction

    function automatic acc_vec_t vadd(input acc_vec_t a, input acc_vec_t b);
        acc_vec_t v;
        for (int c = 0; c < PKG_TILE_SIZE; c++) v[c] = a[c] + b[c];
        return v;
    endfunction

    function automatic acc_vec_t vfill(input int x);
        acc_vec_t v;
        for (int c = 0; c < PKG_TILE_SIZE; c++) v[c] = acc_elem_t'(x);
        return v;
    endfunction

    function automatic acc_tile_t fill(input int x);
        acc_tile_t t;
        for (int r = 0; r < PKG_TILE_SIZE; r++)
            for (int c = 0; c < PKG_TILE_SIZE; c++) t[r][c] = acc_elem_t'(x);
        return t;
    endfunction

    function automatic acc_tile_t colidx(input int k);
        acc_tile_t t;
        for (int r = 0; r < PKG_TILE_SIZE; r++)
            for (int c = 0; c < PKG_TILE_SIZE; c++) t[r][c] = acc_elem_t'(k * c);
        return t;
    endfunction

    function automatic acc_tile_t rand_tile();
        acc_tile_t t;
        for (int r = 0; r < PKG_TILE_SIZE; r++)
            for (int c = 0; c < PKG_TILE_SIZE; c++)
                t[r][c] = acc_elem_t'(int'($urandom_range(0, 2000)) - 1000);
        return t;
    endfunction

    // Behavioural accumulator: clear wins, 2-cycle latency, clear emits a zero pulse.
    logic     p1_v = 1'b0, p2_v = 1'b0;
    acc_vec_t acc_r = '0, p1_vec = '0, p2_vec = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            p1_v <= 1'b0; p2_v <= 1'b0;
            acc_r <= '0; p1_vec <= '0; p2_vec <= '0;
        end else begin
            if (acc_clear) begin
                acc_r <= '0; p1_vec <= '0; p1_v <= 1'b1;
            end else if (acc_valid_in) begin
                if (acc_mode == MODE_MAC) begin
                    acc_r  <= vadd(acc_r, colsum(acc_mat));
                    p1_vec <= vadd(acc_r, colsum(acc_mat));
                end else begin
                    p1_vec <= colsum(acc_mat);
                end
                p1_v <= 1'b1;
            end else begin
                p1_v <= 1'b0;
            end
            p2_v   <= p1_v;
            p2_vec <= p1_vec;
        end
    end
    assign acc_vec_out   = p2_vec;
    assign acc_valid_out = p2_v;

    always @(posedge clk) begin
        if (acc_clear) clr_cnt <= clr_cnt + 1;
        if (acc_valid_in) vin_cnt <= vin_cnt + 1;
        if (cmd_err) err_cnt <= err_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (acc_clear && acc_valid_in) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    // Issues one command and drives tiles[0..len-1]; gap_mode 0 none, 1 alternate, 2 random.
    task automatic run_cmd(input logic [2:0] mode, input int len, input int gap_mode,
                           input int rdy_mode, input string name);
        acc_vec_t exp_q[$];
        acc_vec_t s;
        int sent = 0, results = 0, nres, last_cyc = 0, e0, o0;
        bit lat_pending = 0;
        e0 = err_cnt; o0 = overlap_cnt;
        if (mode == MODE_MAC) begin
            s = '0;
            for (int i = 0; i < len; i++) s = vadd(s, colsum(tiles[i]));
            exp_q.push_back(s);
            nres = 1;
        end else begin
            for (int i = 0; i < len; i++) exp_q.push_back(colsum(tiles[i]));
            nres = len;
        end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_len = 8'(len);
        smp;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready got %b want 1", name, cmd_ready);
        else n_pass++;
        next;
        cmd_valid = 1'b0;
        for (int t = 0; t < 400 && results < nres; t++) begin
            tile_valid = (sent < len) && ((gap_mode == 0) || (gap_mode == 1 && (t % 2) == 0) ||
                         (gap_mode == 2 && $urandom_range(0, 2) != 0));
            tile_data  = (sent < len) ? tiles[sent] : '0;
            res_ready  = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            smp;
            if (tile_valid && tile_ready) begin
                sent++;
                if (mode != MODE_MAC || sent == len) begin
                    lat_pending = 1; last_cyc = t;
                end
            end
            if (res_valid && lat_pending) begin
                lat_pending = 0;
                n_checks++;
                if (t - last_cyc != 3)
                    $display("FAIL %s latency got %0d want 3", name, t - last_cyc);
                else n_pass++;
            end
            if (res_valid && res_ready) begin
                s = exp_q.pop_front();
                results++;
                n_checks++;
                if (res_vec !== s) $display("FAIL %s result got %h want %h", name, res_vec, s);
                else n_pass++;
            end
            next;
        end
        tile_valid = 1'b0; res_ready = 1'b0;
        smp;
        n_checks++;
        if (results != nres || busy !== 1'b0 || err_cnt != e0 || overlap_cnt != o0)
            $display("FAIL %s completion results %0d/%0d busy %b errs %0d overlaps %0d want all done idle 0 0",
                     name, results, nres, busy, err_cnt - e0, overlap_cnt - o0);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next; next;
        smp;
        n_checks++;
        if (cmd_ready !== 0 || tile_ready !== 0 || acc_valid_in !== 0 || acc_clear !== 0 ||
            res_valid !== 0 || busy !== 0 || cmd_err !== 0 || acc_mode !== 3'b000 || res_vec !== '0)
            $display("FAIL reset outputs rdy %b trdy %b vin %b clr %b rv %b busy %b err %b mode %b vec %h want all 0",
                     cmd_ready, tile_ready, acc_valid_in, acc_clear, res_valid, busy, cmd_err, acc_mode, res_vec);
        else n_pass++;
        rst_n = 1'b1;
        next;
        smp;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_idle cmd_ready %b busy %b want 1 0", cmd_ready, busy);
        else n_pass++;
    endtask

    task automatic test_mac_b2b();
        int cyc_n, rv_cyc, c0;
        c0 = clr_cnt;
        cmd_valid = 1'b1; cmd_mode = MODE_MAC; cmd_len = 8'd3;
        tile_valid = 1'b1; tile_data = fill(1);
        smp;
        next;
        cmd_valid = 1'b0;
        smp;
        n_checks++;
        if (acc_clear !== 1'b1 || acc_valid_in !== 1'b0 || tile_ready !== 1'b0)
            $display("FAIL mac_clear clr %b vin %b trdy %b want 1 0 0", acc_clear, acc_valid_in, tile_ready);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            next;
            tile_data = fill(k + 1);
            smp;
            n_checks++;
            if (acc_valid_in !== 1'b1 || acc_mat !== fill(k + 1) || acc_mode !== MODE_MAC)
                $display("FAIL mac_issue%0d vin %b mode %b want 1 000", k, acc_valid_in, acc_mode);
            else n_pass++;
        end
        next;
        tile_valid = 1'b0;
        cyc_n = 5; rv_cyc = -1;
        while (cyc_n < 20 && rv_cyc < 0) begin
            smp;
            if (res_valid) rv_cyc = cyc_n;
            else begin next; cyc_n++; end
        end
        n_checks++;
        if (rv_cyc != 7) $display("FAIL mac_res_cycle got %0d want 7", rv_cyc);
        else n_pass++;
        n_checks++;
        if (res_vec !== vfill(24)) $display("FAIL mac_res_vec got %h want %h", res_vec, vfill(24));
        else n_pass++;
        res_ready = 1'b1;
        next;
        res_ready = 1'b0;
        smp;
        n_checks++;
        if (busy !== 1'b0 || clr_cnt - c0 != 1)
            $display("FAIL mac_done busy %b clears %0d want 0 1", busy, clr_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_outer();
        int c0;
        c0 = clr_cnt;
        tiles[0] = colidx(1);
        tiles[1] = colidx(2);
        run_cmd(MODE_OUTER, 2, 0, 0, "outer");
        n_checks++;
        if (clr_cnt != c0) $display("FAIL outer_noclear clears got %0d want 0", clr_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int v0, b0, e0;
        logic [2:0] modes [2];
        logic [7:0] lens  [2];
        modes[0] = 3'b001; lens[0] = 8'd2;
        modes[1] = MODE_MAC; lens[1] = 8'd0;
        v0 = vin_cnt; b0 = busy_cnt; e0 = err_cnt;
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'b1; cmd_mode = modes[i]; cmd_len = lens[i];
            smp;
            n_checks++;
            if (cmd_err !== 1'b1) $display("FAIL illegal%0d cmd_err got %b want 1", i, cmd_err);
            else n_pass++;
            next;
            cmd_valid = 1'b0;
            smp;
            n_checks++;
            if (cmd_err !== 1'b0 || busy !== 1'b0)
                $display("FAIL illegal%0d after err %b busy %b want 0 0", i, cmd_err, busy);
            else n_pass++;
            next;
        end
        n_checks++;
        if (vin_cnt != v0 || busy_cnt != b0 || err_cnt - e0 != 2)
            $display("FAIL illegal_side issues %0d busy %0d errs %0d want 0 0 2",
                     vin_cnt - v0, busy_cnt - b0, err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        acc_vec_t held;
        acc_tile_t t0, t1;
        int n;
        bit ok;
        t0 = rand_tile(); t1 = rand_tile();
        cmd_valid = 1'b1; cmd_mode = MODE_OUTER; cmd_len = 8'd2;
        next;
        cmd_valid = 1'b0; tile_valid = 1'b1; tile_data = t0;
        smp;
        next;
        tile_data = t1;
        n = 0;
        smp;
        while (!res_valid && n < 10) begin next; smp; n++; end
        held = res_vec;
        ok = 1;
        for (int k = 0; k < 5; k++) begin
            if (res_valid !== 1'b1 || res_vec !== held || tile_ready !== 1'b0 || acc_valid_in !== 1'b0) ok = 0;
            next; smp;
        end
        n_checks++;
        if (!ok || res_vec !== held) $display("FAIL bp_hold vec %h want %h stable, tile_ready 0", res_vec, held);
        else n_pass++;
        n_checks++;
        if (held !== colsum(t0)) $display("FAIL bp_first got %h want %h", held, colsum(t0));
        else n_pass++;
        res_ready = 1'b1;
        next;
        res_ready = 1'b0;
        smp;
        n_checks++;
        if (tile_ready !== 1'b1 || acc_valid_in !== 1'b1 || acc_mat !== t1)
            $display("FAIL bp_second_accept trdy %b vin %b want 1 1", tile_ready, acc_valid_in);
        else n_pass++;
        next;
        tile_valid = 1'b0;
        n = 0;
        smp;
        while (!res_valid && n < 10) begin next; smp; n++; end
        n_checks++;
        if (res_valid !== 1'b1 || res_vec !== colsum(t1))
            $display("FAIL bp_second valid %b got %h want %h", res_valid, res_vec, colsum(t1));
        else n_pass++;
        res_ready = 1'b1;
        next;
        res_ready = 1'b0;
        smp;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL bp_idle busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) tiles[i] = rand_tile();
        run_cmd(MODE_MAC, 4, 1, 0, "gaps");
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_mode = MODE_MAC; cmd_len = 8'd4;
        next;
        cmd_valid = 1'b0;
        next;
        tile_valid = 1'b1; tile_data = rand_tile();
        next;
        tile_data = rand_tile();
        next;
        rst_n = 1'b0;
        smp;
        n_checks++;
        if (tile_ready !== 1'b0 || acc_valid_in !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_mid_during trdy %b vin %b busy %b want 0 0 0", tile_ready, acc_valid_in, busy);
        else n_pass++;
        next;
        rst_n = 1'b1; tile_valid = 1'b0;
        smp;
        n_checks++;
        if (busy !== 0 || cmd_ready !== 1 || res_valid !== 0 || acc_mode !== 3'b000 ||
            res_vec !== '0 || acc_clear !== 0 || acc_valid_in !== 0 || cmd_err !== 0)
            $display("FAIL rst_mid_after busy %b rdy %b rv %b mode %b vec %h want 0 1 0 000 0",
                     busy, cmd_ready, res_valid, acc_mode, res_vec);
        else n_pass++;
        tiles[0] = fill(5);
        run_cmd(MODE_MAC, 1, 0, 0, "rst_fresh");
    endtask

    task automatic test_random();
        int c0, len;
        logic [2:0] mode;
        for (int it = 0; it < 8; it++) begin
            mode = ($urandom_range(0, 1) == 0) ? MODE_MAC : MODE_OUTER;
            len  = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) tiles[i] = rand_tile();
            c0 = clr_cnt;
            run_cmd(mode, len, 2, 2, "random");
            n_checks++;
            if (clr_cnt - c0 != ((mode == MODE_MAC) ? 1 : 0))
                $display("FAIL random_clears mode %b got %0d", mode, clr_cnt - c0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_mac_b2b();
        test_outer();
        test_illegal();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
